// File: rtl/core_array_ctrl.sv
// core_array_ctrl: control plane for the GPU core array.
// Decodes misc opcodes (opcode[15:14] == 2'b11), owns the global register
// file and the per-core enable mask, and serialises one core's accumulator
// LSBs onto a bit-serial output (valid_bit / output_bit / busy / overrun).
// Optional feature macro: CORE_ARRAY_MASK_TOGGLE_EN (mode 2'b11 toggles one
// mask bit when defined; no-op otherwise).
module core_array_ctrl #(
    parameter int NR_CORES       = 4,
    parameter int BIT_WIDTH      = 8,
    parameter int NR_GLOBAL_REGS = 9,
    parameter int OUT_WIDTH      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [15:0]                         opcode,
    input  logic                                execute,
    input  logic [NR_CORES*2*BIT_WIDTH-1:0]     accu_flat,
    output logic [NR_CORES-1:0]                 execute_core,
    output logic [NR_GLOBAL_REGS*BIT_WIDTH-1:0] global_regs_flat,
    output logic                                valid_bit,
    output logic                                output_bit,
    output logic                                busy,
    output logic                                overrun
);

    localparam int ACC_W = 2 * BIT_WIDTH;
    localparam int CNT_W = $clog2(OUT_WIDTH + 1);

    // Architectural state
    logic [NR_CORES-1:0]  enable_mask;
    logic [BIT_WIDTH-1:0] greg [NR_GLOBAL_REGS];
    logic [OUT_WIDTH-1:0] shreg_p1;
    logic [CNT_W-1:0]     cnt_p1;
    logic                 last_bit_p1;
    logic                 overrun_r;

    // Decoded command fields and derived controls
    logic                      misc;
    logic [4:0]                idx;
    logic                      store;
    logic [1:0]                mode;
    logic                      out_cmd;
    logic [NR_CORES-1:0]       idx_core_oh;
    logic [NR_GLOBAL_REGS-1:0] idx_reg_oh;
    logic                      src_found;
    logic [BIT_WIDTH-1:0]      src_data;
    logic [OUT_WIDTH-1:0]      sel_bits;
    logic [NR_CORES-1:0]       mask_nxt;
    logic                      out_accept;
    logic                      out_drop;

    // Opcode bits this block never looks at
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^{opcode[8], opcode[3:0]};

    assign misc    = execute && (opcode[15:14] == 2'b11);
    assign idx     = opcode[13:9];
    assign store   = opcode[7];
    assign mode    = opcode[6:5];
    assign out_cmd = opcode[4];

    assign busy         = (cnt_p1 != '0);
    assign valid_bit    = busy;
    assign output_bit   = busy ? shreg_p1[0] : last_bit_p1;
    assign overrun      = overrun_r;
    assign execute_core = enable_mask & {NR_CORES{execute}};

    for (genvar z = 0; z < NR_GLOBAL_REGS; z++) begin : g_flat
        assign global_regs_flat[z*BIT_WIDTH +: BIT_WIDTH] = greg[z];
    end

    // Decode: index one-hots, store source (lowest enabled core), next mask, output accept/drop
    always_comb begin
        idx_core_oh = '0;
        idx_reg_oh  = '0;
        src_found   = 1'b0;
        src_data    = '0;
        sel_bits    = '0;
        mask_nxt    = enable_mask;
        out_accept  = 1'b0;
        out_drop    = 1'b0;

        // Walk downward so the lowest enabled core is the one left selected
        for (int k = NR_CORES - 1; k >= 0; k--) begin
            if (enable_mask[k]) begin
                src_found = 1'b1;
                src_data  = accu_flat[k*ACC_W +: BIT_WIDTH];
            end
            idx_core_oh[k] = (idx == 5'(k));
            if (idx_core_oh[k]) begin
                sel_bits = accu_flat[k*ACC_W +: OUT_WIDTH];
            end
        end

        for (int z = 0; z < NR_GLOBAL_REGS; z++) begin
            idx_reg_oh[z] = (idx == 5'(z));
        end

        // An out-of-range idx leaves idx_core_oh all zero, which gives the
        // required "all zeros" for mode 01 and "no change" for toggling.
        case (mode)
            2'b01:   mask_nxt = idx_core_oh;
            2'b10:   mask_nxt = '1;
`ifdef CORE_ARRAY_MASK_TOGGLE_EN
            2'b11:   mask_nxt = enable_mask ^ idx_core_oh;
`else
            2'b11:   mask_nxt = enable_mask;
`endif
            default: mask_nxt = enable_mask;
        endcase

        if (misc && out_cmd && (|idx_core_oh)) begin
            out_accept = !busy;
            out_drop   = busy;
        end
    end

    // State update: register file, enable mask, serialiser and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_mask <= '1;
            for (int z = 0; z < NR_GLOBAL_REGS; z++) begin
                greg[z] <= '0;
            end
            shreg_p1    <= '0;
            cnt_p1      <= '0;
            last_bit_p1 <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (misc) begin
                if (store && src_found) begin
                    for (int z = 0; z < NR_GLOBAL_REGS; z++) begin
                        if (idx_reg_oh[z]) begin
                            greg[z] <= src_data;
                        end
                    end
                end
                enable_mask <= mask_nxt;
            end
            // Stage p1: serial shift register, one bit presented per busy cycle
            if (out_accept) begin
                shreg_p1 <= sel_bits;
                cnt_p1   <= CNT_W'(OUT_WIDTH);
            end else if (busy) begin
                last_bit_p1 <= shreg_p1[0];
                shreg_p1    <= shreg_p1 >> 1;
                cnt_p1      <= cnt_p1 - CNT_W'(1);
            end
            if (out_drop) begin
                overrun_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_array_ctrl.sv
// Self-checking bench for core_array_ctrl (NR_CORES=4, BIT_WIDTH=8,
// NR_GLOBAL_REGS=9, OUT_WIDTH=4). A transaction-level model predicts the
// mask, registers, busy window and overrun; expected serial bits go into a
// queue that a negedge monitor drains whenever valid_bit is high.
module tb_core_array_ctrl;

    localparam int NC = 4;
    localparam int BW = 8;
    localparam int NG = 9;
    localparam int OW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [15:0]           opcode = '0;
    logic                  execute = 1'b0;
    logic [NC*2*BW-1:0]    accu_flat = '0;
    logic [NC-1:0]         execute_core;
    logic [NG*BW-1:0]      global_regs_flat;
    logic                  valid_bit;
    logic                  output_bit;
    logic                  busy;
    logic                  overrun;

    core_array_ctrl #(
        .NR_CORES(NC), .BIT_WIDTH(BW), .NR_GLOBAL_REGS(NG), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .execute(execute),
        .accu_flat(accu_flat), .execute_core(execute_core),
        .global_regs_flat(global_regs_flat), .valid_bit(valid_bit),
        .output_bit(output_bit), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [NC-1:0] m_mask;
    logic [BW-1:0] m_greg [NG];
    int            busy_until;
    logic          m_ovr;
    int            edge_n = 0;
    logic          exp_q [$];
    logic          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [15:0] accu_of(input int k);
        return accu_flat[k*16 +: 16];
    endfunction

    function automatic int lowest_en();
        for (int k = 0; k < NC; k++) if (m_mask[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_mask = '1;
        for (int z = 0; z < NG; z++) m_greg[z] = '0;
        busy_until = -100;
        m_ovr = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_state();
        chk("busy", busy, (edge_n <= busy_until));
        chk("valid_bit", valid_bit, (edge_n <= busy_until));
        chk("overrun", overrun, m_ovr);
        for (int z = 0; z < NG; z++) chk($sformatf("greg%0d", z), global_regs_flat[z*BW +: BW], m_greg[z]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        execute = 1'b0;
        @(posedge clk);
        edge_n++;
        model_reset();
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        check_state();
    endtask

    // One clock: drive the command, predict its effect from pre-command state, check after the edge
    task automatic do_cycle(input logic [15:0] op, input logic ex);
        int idx, k, n;
        logic [15:0] a;
        opcode = op;
        execute = ex;
        #1;
        chk("execute_core", execute_core, m_mask & {NC{ex}});
        n = edge_n + 1;
        if (ex && op[15:14] == 2'b11) begin
            idx = int'(op[13:9]);
            if (op[7]) begin
                k = lowest_en();
                if (k >= 0 && idx < NG) begin
                    a = accu_of(k);
                    m_greg[idx] = a[7:0];
                end
            end
            case (op[6:5])
                2'b01: m_mask = (idx < NC) ? NC'(1 << idx) : '0;
                2'b10: m_mask = '1;
                2'b11: begin
`ifdef CORE_ARRAY_MASK_TOGGLE_EN
                    if (idx < NC) m_mask = m_mask ^ NC'(1 << idx);
`endif
                end
                default: ;
            endcase
            if (op[4] && idx < NC) begin
                if (n - 1 > busy_until) begin
                    busy_until = n + OW - 1;
                    a = accu_of(idx);
                    for (int i = 0; i < OW; i++) exp_q.push_back(a[i]);
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
        check_state();
    endtask

    // Monitor: every valid bit must match the next expected bit
    initial begin
        logic b;
        forever begin
            @(negedge clk);
            if (mon_en && valid_bit === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL output_bit: got unexpected valid bit %0b, expected no bit", output_bit);
                end else begin
                    b = exp_q.pop_front();
                    chk("output_bit", output_bit, b);
                end
            end
        end
    end

    initial begin
        logic [15:0] op;
        logic [3:0]  exp_tog;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state
        do_cycle(16'h0000, 1'b1);
        chk("reset_execute_core", execute_core, 4'b1111);
        chk("reset_globals_zero", |global_regs_flat, 1'b0);
        chk("reset_overrun", overrun, 1'b0);

        // Mode 01 idx 2, then store to reg 5 from core 2
        accu_flat[2*16 +: 16] = 16'hAB5A;
        do_cycle(16'hC420, 1'b1);
        do_cycle(16'hCA80, 1'b1);
        chk("mode01_execute_core", execute_core, 4'b0100);
        chk("store_greg5", global_regs_flat[5*8 +: 8], 8'h5A);

        // Output stream from core 1, then a dropped command two cycles later
        do_cycle(16'hC040, 1'b1);
        accu_flat[1*16 +: 16] = 16'h000B;
        do_cycle(16'hC210, 1'b1);
        accu_flat[1*16 +: 16] = 16'hFFF4;
        do_cycle(16'h0000, 1'b0);
        do_cycle(16'hC210, 1'b1);
        chk("overrun_set", overrun, 1'b1);
        repeat (6) do_cycle(16'h0000, 1'b0);
        chk("overrun_sticky", overrun, 1'b1);
        do_reset();
        chk("overrun_cleared", overrun, 1'b0);

        // Store uses the old mask while mode 01 selects core 3
        accu_flat[0 +: 16] = 16'h1234;
        do_cycle(16'hC6A0, 1'b1);
        chk("store_old_mask", global_regs_flat[3*8 +: 8], 8'h34);
        do_cycle(16'h0000, 1'b1);
        chk("mask_onehot3", execute_core, 4'b1000);

        // Mode 11 toggle
        do_cycle(16'hC040, 1'b1);
        do_cycle(16'hC060, 1'b1);
        do_cycle(16'h0000, 1'b1);
`ifdef CORE_ARRAY_MASK_TOGGLE_EN
        exp_tog = 4'b1110;
`else
        exp_tog = 4'b1111;
`endif
        chk("toggle_idx0", execute_core, exp_tog);
        do_cycle(16'hC460, 1'b1);
        do_cycle(16'h0000, 1'b1);
`ifdef CORE_ARRAY_MASK_TOGGLE_EN
        exp_tog = 4'b1010;
`endif
        chk("toggle_idx2", execute_core, exp_tog);

        // Randomised traffic
        for (int c = 0; c < 600; c++) begin
            accu_flat = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                op = 16'($urandom);
                if ($urandom_range(0, 3) != 0) op[15:14] = 2'b11;
                if ($urandom_range(0, 3) != 0) op[13:9] = 5'($urandom_range(0, 9));
                do_cycle(op, ($urandom_range(0, 4) != 0));
            end
        end

        // Drain
        repeat (OW + 4) do_cycle(16'h0000, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
